wb_stage: RTL

//  Write-back stage of the 5-stage RV64 core; consumes the registered MEM/WB pipeline fields.

---
 rtl/wb_if.sv | 39 +++
 rtl/wb_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/wb_if.sv
// Write-back stage bus: registered MEM/WB fields in, regfile write port and commit record out.
// The pipeline drives through the master modport; wb_stage attaches to the slave modport.
interface wb_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] wb_alu_result;
  logic [XLEN-1:0] wb_mem_data;
  logic            wb_mem_to_reg;
  logic            wb_mem_ext_un;
  logic [7:0]      wb_mem_byte_enable;
  logic            wb_rd_wena;
  logic [4:0]      wb_rd_waddr;
  logic [XLEN-1:0] wb_pc;
  logic [31:0]     wb_inst;
  logic            wb_csr_rena;
  logic            wb_csr_wena;
  logic [1:0]      wb_csr_op;
  logic [XLEN-1:0] wb_new_rs1_data;
  logic            rf_wena;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     commit_inst;

  modport master (
    output wb_alu_result, wb_mem_data, wb_mem_to_reg, wb_mem_ext_un, wb_mem_byte_enable,
           wb_rd_wena, wb_rd_waddr, wb_pc, wb_inst, wb_csr_rena, wb_csr_wena, wb_csr_op,
           wb_new_rs1_data,
    input  rf_wena, rf_waddr, rf_wdata, commit_valid, commit_pc, commit_inst
  );

  modport slave (
    input  wb_alu_result, wb_mem_data, wb_mem_to_reg, wb_mem_ext_un, wb_mem_byte_enable,
           wb_rd_wena, wb_rd_waddr, wb_pc, wb_inst, wb_csr_rena, wb_csr_wena, wb_csr_op,
           wb_new_rs1_data,
    output rf_wena, rf_waddr, rf_wdata, commit_valid, commit_pc, commit_inst
  );
endinterface

// File: rtl/wb_stage.sv
// RV64 write-back stage: load extraction, GPR write-back select, machine CSR file, commit record.
// Define WB_COUNTERS_EN to implement mcycle/minstret; otherwise they read 0 and ignore writes.
module wb_stage #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input logic clk,
  input logic rst,
  wb_if.slave wb
);
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  logic            retire;
  logic [11:0]     csr_addr;
  logic            csr_we;
  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] csr_wdata;

  logic [3:0]      ld_size;
  logic [2:0]      ld_shift;
  logic [XLEN-1:0] ld_field;
  logic [XLEN-1:0] ld_value;

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
`ifdef WB_COUNTERS_EN
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;
`endif

  logic            commit_valid_q;
  logic [XLEN-1:0] commit_pc_q;
  logic [31:0]     commit_inst_q;

  assign retire   = (wb.wb_inst != 32'd0);
  assign csr_addr = wb.wb_inst[31:20];
  assign csr_we   = wb.wb_csr_wena & retire & (wb.wb_csr_op != 2'b00);

  // Only naturally aligned 1/2/4/8-byte lane groups are legal; anything else leaves size 0.
  always_comb begin
    ld_size  = 4'd0;
    ld_shift = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (wb.wb_mem_byte_enable == (8'h01 << i)) begin
        ld_size  = 4'd1;
        ld_shift = 3'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (wb.wb_mem_byte_enable == (8'h03 << (2 * i))) begin
        ld_size  = 4'd2;
        ld_shift = 3'(2 * i);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (wb.wb_mem_byte_enable == (8'h0F << (4 * i))) begin
        ld_size  = 4'd4;
        ld_shift = 3'(4 * i);
      end
    end
    if (wb.wb_mem_byte_enable == 8'hFF) begin
      ld_size  = 4'd8;
      ld_shift = 3'd0;
    end
  end

  assign ld_field = wb.wb_mem_data >> {ld_shift, 3'b000};

  always_comb begin
    ld_value = '0;
    case (ld_size)
      4'd1: ld_value = {{(XLEN-8){ld_field[7] & ~wb.wb_mem_ext_un}}, ld_field[7:0]};
      4'd2: ld_value = {{(XLEN-16){ld_field[15] & ~wb.wb_mem_ext_un}}, ld_field[15:0]};
      4'd4: ld_value = {{(XLEN-32){ld_field[31] & ~wb.wb_mem_ext_un}}, ld_field[31:0]};
      4'd8: ld_value = ld_field;
      default: ld_value = '0;
    endcase
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_q;
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
`ifdef WB_COUNTERS_EN
      CSR_MCYCLE:   csr_rdata = mcycle_q;
      CSR_MINSTRET: csr_rdata = minstret_q;
`endif
      default:      csr_rdata = '0;
    endcase
  end

  always_comb begin
    csr_wdata = csr_rdata;
    case (wb.wb_csr_op)
      2'b01:   csr_wdata = wb.wb_new_rs1_data;
      2'b10:   csr_wdata = csr_rdata | wb.wb_new_rs1_data;
      2'b11:   csr_wdata = csr_rdata & ~wb.wb_new_rs1_data;
      default: csr_wdata = csr_rdata;
    endcase
  end

  // Counter increments are the defaults; a CSR write to the same counter overrides them.
  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
`ifdef WB_COUNTERS_EN
    mcycle_d   = mcycle_q + 1'b1;
    minstret_d = minstret_q + {{(XLEN-1){1'b0}}, retire};
`endif
    if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS:  mstatus_d  = csr_wdata;
        CSR_MTVEC:    mtvec_d    = csr_wdata;
        CSR_MSCRATCH: mscratch_d = csr_wdata;
        CSR_MEPC:     mepc_d     = csr_wdata;
        CSR_MCAUSE:   mcause_d   = csr_wdata;
`ifdef WB_COUNTERS_EN
        CSR_MCYCLE:   mcycle_d   = csr_wdata;
        CSR_MINSTRET: minstret_d = csr_wdata;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_q      <= '0;
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
`ifdef WB_COUNTERS_EN
      mcycle_q       <= '0;
      minstret_q     <= '0;
`endif
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_inst_q  <= '0;
    end else begin
      mstatus_q      <= mstatus_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
`ifdef WB_COUNTERS_EN
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
`endif
      commit_valid_q <= retire;
      commit_pc_q    <= wb.wb_pc;
      commit_inst_q  <= wb.wb_inst;
    end
  end

  assign wb.rf_wena  = wb.wb_rd_wena & retire & (wb.wb_rd_waddr != 5'd0);
  assign wb.rf_waddr = wb.wb_rd_waddr;
  assign wb.rf_wdata = wb.wb_csr_rena   ? csr_rdata :
                       wb.wb_mem_to_reg ? ld_value  : wb.wb_alu_result;

  assign wb.commit_valid = commit_valid_q;
  assign wb.commit_pc    = commit_pc_q;
  assign wb.commit_inst  = commit_inst_q;
endmodule
